mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous SRAM between the core's instruction-fetch port (F stage) and data port (M stage). Used when ITCM and DTCM are merged into one unified memory.
- Arbitrates with req/gnt handshakes and sequences the RAM read latency with a small FSM.
- Returns read data to the owning port with a one-cycle valid pulse.
- Sits between the rv_core top level and the unified RAM macro.

---
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch port, the data port and the unified
// RAM port that meet at mem_port_arbiter.
//   slave  - the arbiter's view (drives grants, read returns and the RAM pins)
//   master - the surrounding core/RAM view (drives requests and RAM read data)
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  // Instruction-fetch port (F stage)
  logic            i_req;
  logic [AW-1:0]   i_addr;
  logic            i_gnt;
  logic            i_rvalid;
  logic [DW-1:0]   i_rdata;

  // Data port (M stage)
  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_wstrb;
  logic            d_gnt;
  logic            d_rvalid;
  logic [DW-1:0]   d_rdata;

  // Unified single-port RAM
  logic            ram_en;
  logic [DW/8-1:0] ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic [DW-1:0]   ram_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_gnt, d_rvalid, d_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_gnt, d_rvalid, d_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous SRAM between the
// instruction-fetch port and the data port of the core.
//   - Grants only while idle; D has fixed priority over I.
//   - Writes complete in the accept cycle; reads park the FSM in WAIT for
//     RD_LAT cycles and return data with a one-cycle rvalid pulse.
//   - Optional starvation guard for the fetch port: define MEM_ARB_STARVE_EN
//     to let I win after STARVE_MAX consecutive D grants taken while I waited.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic              busy
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state;
  logic [2:0]    rd_cnt;
  logic          rd_own;      // 0 = fetch port owns the read, 1 = data port
  logic          i_rvalid;
  logic          d_rvalid;
  logic [DW-1:0] i_rdata;
  logic [DW-1:0] d_rdata;

  logic          gnt_i;
  logic          gnt_d;
  logic          rd_accept;
  logic          starve_hit;

`ifdef MEM_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;

  // Count D grants taken while I was left waiting; any I grant or idle I resets it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (gnt_i || !bus.i_req) begin
      starve_cnt <= '0;
    end else if (gnt_d && (starve_cnt != SW'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  assign starve_hit = (starve_cnt == SW'(STARVE_MAX));
`else
  // Without the guard the arbiter is pure D > I; STARVE_MAX has no effect.
  logic unused_starve_max;
  assign unused_starve_max = (STARVE_MAX > 0);
  assign starve_hit        = 1'b0;
`endif

  // Arbitrate in IDLE only; grants are masked while reset is held so nothing
  // is accepted (and no RAM write happens) during reset.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if ((state == IDLE) && !rst) begin
      if (bus.d_req && !(bus.i_req && starve_hit)) begin
        gnt_d = 1'b1;
      end else if (bus.i_req) begin
        gnt_i = 1'b1;
      end
    end
  end

  // A read is any fetch accept or a non-write data accept.
  assign rd_accept = gnt_i || (gnt_d && !bus.d_we);

  assign bus.i_gnt = gnt_i;
  assign bus.d_gnt = gnt_d;

  // RAM is driven straight from the winning request in its accept cycle;
  // the address defaults to the data port when nothing is granted.
  assign bus.ram_en    = gnt_i || gnt_d;
  assign bus.ram_addr  = gnt_i ? bus.i_addr : bus.d_addr;
  assign bus.ram_wdata = bus.d_wdata;
  assign bus.ram_we    = (gnt_d && bus.d_we) ? bus.d_wstrb : '0;

  // Read sequencer: load the latency on accept, count down in WAIT and hand
  // ram_rdata to the owning port on the last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rd_cnt   <= 3'd0;
      rd_own   <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_accept) begin
            state  <= WAIT;
            rd_cnt <= 3'(RD_LAT);
            rd_own <= gnt_d;
          end
        end
        WAIT: begin
          rd_cnt <= rd_cnt - 3'd1;
          if (rd_cnt == 3'd1) begin
            state <= IDLE;
            if (rd_own) begin
              d_rdata  <= bus.ram_rdata;
              d_rvalid <= 1'b1;
            end else begin
              i_rdata  <= bus.ram_rdata;
              i_rvalid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.i_rvalid = i_rvalid;
  assign bus.i_rdata  = i_rdata;
  assign bus.d_rvalid = d_rvalid;
  assign bus.d_rdata  = d_rdata;
  assign busy         = (state == WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a read-return scoreboard.
// Expected read returns (data and cycle) are queued at grant time and the
// monitor pops them whenever i_rvalid or d_rvalid fires. RD_LAT = 2.
module tb_mem_port_arbiter;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 4;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t iq[$];
  exp_t dq[$];
  exp_t mon_i;
  exp_t mon_d;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus();

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: byte-enable writes, RD_LAT-stage read pipeline
  logic [31:0] mem [0:255];
  logic [31:0] pipe [RD_LAT];
  logic        mem_load = 1'b1;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int j = 0; j < 256; j++) mem[j] <= 32'h0;
      mem[8'h40] <= 32'h0000_0013;   // 0x100
      mem[8'h43] <= 32'h0000_0073;   // 0x10C
      mem[8'h81] <= 32'h1122_3344;   // 0x204
      mem[8'h82] <= 32'hA5A5_0001;   // 0x208
    end else if (bus.ram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_we[b]) mem[bus.ram_addr[9:2]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    end
    pipe[0] <= mem[bus.ram_addr[9:2]];
    for (int s = 1; s < RD_LAT; s++) pipe[s] <= pipe[s-1];
  end
  assign bus.ram_rdata = pipe[RD_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) begin
      next_cycle();
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      bus.d_we  = 1'b0;
    end
  endtask

  task automatic d_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    next_cycle();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = addr; bus.d_wdata = data; bus.d_wstrb = strb;
    @(negedge clk);
    chk("wr_d_gnt", bus.d_gnt, 1);
    chk("wr_ram_en", bus.ram_en, 1);
    chk("wr_ram_we", bus.ram_we, strb);
    chk("wr_ram_addr", bus.ram_addr, addr);
    chk("wr_ram_wdata", bus.ram_wdata, data);
    $display("txn D write addr=%h data=%h strb=%b cycle=%0d", addr, data, strb, cyc);
  endtask

  task automatic d_read(input logic [31:0] addr, input logic [31:0] data);
    next_cycle();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = addr;
    @(negedge clk);
    chk("rd_d_gnt", bus.d_gnt, 1);
    chk("rd_ram_we", bus.ram_we, 0);
    chk("busy_at_accept", busy, 0);
    dq.push_back('{data, cyc + RD_LAT + 1});
    $display("txn D read addr=%h cycle=%0d", addr, cyc);
    settle(RD_LAT + 1);
  endtask

  // Monitor: every rvalid pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.i_rvalid) begin
        $display("txn I return data=%h cycle=%0d", bus.i_rdata, cyc);
        if (iq.size() == 0) begin
          checks++; errors++;
          $display("FAIL i_rvalid_spurious: got pulse data %h want none (cycle %0d)", bus.i_rdata, cyc);
        end else begin
          mon_i = iq.pop_front();
          chk("i_rdata", bus.i_rdata, mon_i.data);
          chk("i_rvalid_cycle", cyc, mon_i.cyc);
        end
      end
      if (bus.d_rvalid) begin
        $display("txn D return data=%h cycle=%0d", bus.d_rdata, cyc);
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL d_rvalid_spurious: got pulse data %h want none (cycle %0d)", bus.d_rdata, cyc);
        end else begin
          mon_d = dq.pop_front();
          chk("d_rdata", bus.d_rdata, mon_d.data);
          chk("d_rvalid_cycle", cyc, mon_d.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before 100000 time units");
    $fatal(1);
  end

  logic exp_d;
  logic exp_i;

  initial begin
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;

    // Reset state
    repeat (2) @(posedge clk);
    mem_load = 1'b0;
    @(negedge clk);
    chk("rst_i_rvalid", bus.i_rvalid, 0);
    chk("rst_d_rvalid", bus.d_rvalid, 0);
    chk("rst_i_rdata", bus.i_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    chk("rst_busy", busy, 0);

    // Fetch read of 0x100 in the first cycle after reset release
    next_cycle();
    rst = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    @(negedge clk);
    chk("f_i_gnt", bus.i_gnt, 1);
    chk("f_d_gnt", bus.d_gnt, 0);
    chk("f_ram_en", bus.ram_en, 1);
    chk("f_ram_addr", bus.ram_addr, 32'h100);
    chk("f_ram_we", bus.ram_we, 0);
    iq.push_back('{32'h0000_0013, cyc + RD_LAT + 1});
    $display("txn I read addr=%h cycle=%0d", 32'h100, cyc);
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      next_cycle();
      bus.i_req = 1'b0;
      @(negedge clk);
      chk("f_busy", busy, (k <= RD_LAT) ? 1 : 0);
    end

    // Partial write then read back; no-op write leaves memory unchanged
    d_write(32'h200, 32'hDEAD_BEEF, 4'b0011);
    d_read(32'h200, 32'h0000_BEEF);
    d_write(32'h204, 32'hFFFF_FFFF, 4'b0000);
    d_read(32'h204, 32'h1122_3344);
    next_cycle();
    @(negedge clk);
    chk("hold_d_rdata", bus.d_rdata, 32'h1122_3344);
    chk("hold_i_rdata", bus.i_rdata, 32'h0000_0013);

    // Both ports request continuously
    next_cycle();
    bus.i_req = 1'b1; bus.i_addr = 32'h10C;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h208;
    for (int k = 0; k < 15; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      exp_d = (k % 3 == 0);
      exp_i = 1'b0;
`ifdef MEM_ARB_STARVE_EN
      if (k == 12) begin exp_d = 1'b0; exp_i = 1'b1; end
`endif
      chk("c_d_gnt", bus.d_gnt, exp_d);
      chk("c_i_gnt", bus.i_gnt, exp_i);
      chk("c_ram_en", bus.ram_en, exp_d | exp_i);
      chk("c_busy", busy, (k % 3 != 0) ? 1 : 0);
      if (exp_i) chk("c_ram_addr", bus.ram_addr, 32'h10C);
      if (exp_d) dq.push_back('{32'hA5A5_0001, cyc + RD_LAT + 1});
      if (exp_i) iq.push_back('{32'h0000_0073, cyc + RD_LAT + 1});
    end
    settle(RD_LAT + 2);

    // Reset pulse in the middle of a fetch read: read discarded
    next_cycle();
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    @(negedge clk);
    chk("r_i_gnt", bus.i_gnt, 1);
    next_cycle();
    bus.i_req = 1'b0;
    @(negedge clk);
    chk("r_busy_before", busy, 1);
    next_cycle();
    #2 rst = 1'b1;
    #1;
    chk("r_busy_async", busy, 0);
    chk("r_i_rdata_async", bus.i_rdata, 0);
    chk("r_d_rdata_async", bus.d_rdata, 0);
    chk("r_i_rvalid_async", bus.i_rvalid, 0);
    next_cycle();
    rst = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h10C;
    @(negedge clk);
    chk("r_i_gnt_after", bus.i_gnt, 1);
    iq.push_back('{32'h0000_0073, cyc + RD_LAT + 1});
    settle(RD_LAT + 2);

    // Four back-to-back writes while fetch waits, then fetch wins
    next_cycle();
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) next_cycle();
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h300 + 32'(4 * k);
      bus.d_wdata = 32'hC0DE_0000 + 32'(k); bus.d_wstrb = 4'hF;
      @(negedge clk);
      chk("bw_d_gnt", bus.d_gnt, 1);
      chk("bw_i_gnt", bus.i_gnt, 0);
      chk("bw_ram_we", bus.ram_we, 4'hF);
      chk("bw_ram_addr", bus.ram_addr, 32'h300 + 32'(4 * k));
      $display("txn D write addr=%h data=%h strb=1111 cycle=%0d", bus.d_addr, bus.d_wdata, cyc);
    end
    next_cycle();
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    @(negedge clk);
    chk("bw_i_gnt_after", bus.i_gnt, 1);
    iq.push_back('{32'h0000_0013, cyc + RD_LAT + 1});
    settle(RD_LAT + 2);
    d_read(32'h30C, 32'hC0DE_0003);
    d_read(32'h300, 32'hC0DE_0000);
    settle(3);

    chk("iq_drained", iq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
